// File: rtl/mem_access.sv
// Memory-access stage: drives one request/ready transaction per load/store and stalls
// upstream until it completes, faults, or times out. Load data is returned left-justified.
module mem_access #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ready,
  input  logic [31:0]     mem_rdata,
  output logic [31:0]     memData,
  output logic            stall,
  output logic            done,
  output logic            misaligned,
  output logic            bus_err
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q;
  logic [7:0]  wait_cnt_q;
  logic        ld_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;

  logic        req;
  logic        f3_ok;
  logic        align_ok;
  logic        legal;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_word;

  always_comb begin
    req = valid_in & (is_load | is_store);

    f3_ok = 1'b0;
    if (is_load) begin
      f3_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else begin
      f3_ok = funct3 inside {3'b000, 3'b001, 3'b010};
    end

    align_ok = 1'b1;
    case (funct3[1:0])
      2'b01:   align_ok = ~addr[0];
      2'b10:   align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase

    legal = ~(is_load & is_store) & f3_ok & align_ok;
  end

  // Store lanes: data replicated across the word, byte enables pick the addressed lanes.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = store_data[31:0];
    if (!is_load) begin
      case (funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << addr[1:0];
          wdata_d = {4{store_data[7:0]}};
        end
        2'b01: begin
          be_d    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{store_data[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = store_data[31:0];
        end
      endcase
    end
  end

  always_comb begin
    load_word = mem_rdata;
    case (size_q)
      2'b00:   load_word = {mem_rdata[8*off_q +: 8], 24'h0};
      2'b01:   load_word = {mem_rdata[16*off_q[1] +: 16], 16'h0};
      default: load_word = mem_rdata;
    endcase
  end

  assign stall = ((state_q == StIdle) & req & legal) | (state_q == StBusy);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= 8'd0;
      ld_q       <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
      mem_be     <= 4'h0;
      memData    <= 32'h0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            if (legal) begin
              mem_req    <= 1'b1;
              mem_we     <= is_store;
              mem_addr   <= {addr[XLEN-1:2], 2'b00};
              mem_be     <= be_d;
              mem_wdata  <= wdata_d;
              ld_q       <= is_load;
              size_q     <= funct3[1:0];
              off_q      <= addr[1:0];
              wait_cnt_q <= 8'd0;
              state_q    <= StBusy;
            end else begin
              misaligned <= 1'b1;
            end
          end
        end
        StBusy: begin
          if (mem_ready) begin
            if (ld_q) begin
              memData <= load_word;
            end
            done      <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            state_q   <= StIdle;
          end else if (wait_cnt_q == 8'(MAX_WAIT - 1)) begin
            bus_err   <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            state_q   <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: each transaction is checked cycle by cycle against a
// transaction-level model of legality, lane selection, latency and timeout.
module tb_mem_access;

  localparam int unsigned MaxWait = 4;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] memData;
  logic        stall;
  logic        done;
  logic        misaligned;
  logic        bus_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mdata    = 32'h0;

  mem_access #(
    .XLEN    (32),
    .MAX_WAIT(MaxWait)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .is_load   (is_load),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .store_data(store_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .memData   (memData),
    .stall     (stall),
    .done      (done),
    .misaligned(misaligned),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit m_legal(bit il, bit is_, logic [2:0] f3, logic [31:0] a);
    int sz = int'(f3) % 4;
    if (!(il || is_)) return 0;
    if (il && is_) return 0;
    if (il && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 0;
    if (is_ && f3 > 2) return 0;
    if (sz == 1 && a % 2 != 0) return 0;
    if (sz == 2 && a % 4 != 0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] m_be(bit il, logic [2:0] f3, logic [31:0] a);
    if (il) return 32'hF;
    case (f3)
      3'd0:    return 32'h1 << (a % 4);
      3'd1:    return 32'h3 << (a % 4);
      default: return 32'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] sd);
    case (f3)
      3'd0:    return (sd & 32'hFF) * 32'h01010101;
      3'd1:    return (sd & 32'hFFFF) * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
    int b  = int'(a % 4);
    int sz = int'(f3) % 4;
    if (sz == 0) return ((rd >> (8 * b)) & 32'hFF) << 24;
    if (sz == 1) return ((rd >> (16 * (b / 2))) & 32'hFFFF) << 16;
    return rd;
  endfunction

  task automatic drive_idle();
    valid_in  = 1'b0;
    is_load   = 1'($urandom);
    is_store  = 1'($urandom);
    funct3    = 3'($urandom);
    addr      = $urandom;
    mem_ready = 1'b0;
    mem_rdata = $urandom;
  endtask

  // One idle cycle with stray mem_ready traffic that must be ignored.
  task automatic idle();
    drive_idle();
    mem_ready = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    check_eq("idle_done", 32'(done), 0);
    check_eq("idle_mis", 32'(misaligned), 0);
    check_eq("idle_buserr", 32'(bus_err), 0);
    check_eq("idle_req", 32'(mem_req), 0);
    check_eq("idle_stall", 32'(stall), 0);
    check_eq("idle_memdata", memData, mdata);
  endtask

  // Presents one op at the current (post-negedge) time; returns in the completion cycle
  // so that a following call is presented during the done pulse.
  task automatic do_op(input bit il, input bit is_, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input int delay,
                       input logic [31:0] rd);
    bit lg  = m_legal(il, is_, f3, a);
    bit got = 0;
    valid_in   = 1'b1;
    is_load    = il;
    is_store   = is_;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    mem_ready  = 1'($urandom);
    mem_rdata  = $urandom;
    #1 check_eq("stall_accept", 32'(stall), 32'(lg));
    @(posedge clk);
    @(negedge clk);
    if (!lg) begin
      drive_idle();
      #1;
      check_eq("fault_mis", 32'(misaligned), 32'(il | is_));
      check_eq("fault_req", 32'(mem_req), 0);
      check_eq("fault_stall", 32'(stall), 0);
      check_eq("fault_done", 32'(done), 0);
      return;
    end
    for (int k = 0; k < int'(MaxWait); k++) begin
      // Upstream noise while busy must not disturb the held request.
      valid_in   = 1'($urandom);
      is_load    = 1'($urandom);
      is_store   = 1'($urandom);
      funct3     = 3'($urandom);
      addr       = $urandom;
      store_data = $urandom;
      mem_ready  = (k == delay);
      mem_rdata  = (k == delay) ? rd : $urandom;
      #1;
      check_eq("busy_req", 32'(mem_req), 1);
      check_eq("busy_we", 32'(mem_we), 32'(is_));
      check_eq("busy_addr", mem_addr, a & 32'hFFFF_FFFC);
      check_eq("busy_be", 32'(mem_be), m_be(il, f3, a));
      if (is_) check_eq("busy_wdata", mem_wdata, m_wdata(f3, sd));
      check_eq("busy_stall", 32'(stall), 1);
      check_eq("busy_done", 32'(done), 0);
      if (k == delay) got = 1;
      @(posedge clk);
      @(negedge clk);
      if (got) break;
    end
    drive_idle();
    if (got && il) mdata = m_load(f3, a, rd);
    #1;
    check_eq("end_done", 32'(done), 32'(got));
    check_eq("end_buserr", 32'(bus_err), 32'(!got));
    check_eq("end_req", 32'(mem_req), 0);
    check_eq("end_be", 32'(mem_be), 0);
    check_eq("end_we", 32'(mem_we), 0);
    check_eq("end_memdata", memData, mdata);
    check_eq("end_stall", 32'(stall), 0);
  endtask

  initial begin
    reset      = 1'b0;
    store_data = 32'h0;
    drive_idle();
    #1;
    check_eq("rst_req", 32'(mem_req), 0);
    check_eq("rst_we", 32'(mem_we), 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_be", 32'(mem_be), 0);
    check_eq("rst_memdata", memData, 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_mis", 32'(misaligned), 0);
    check_eq("rst_buserr", 32'(bus_err), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases
    do_op(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'hAABBCCDD);
    check_eq("lb_value", memData, 32'hAA000000);
    idle();
    do_op(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 2, 32'h0);
    idle();
    do_op(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
    do_op(0, 1, 3'b001, 32'h7, 32'h0, 0, 32'h0);
    do_op(1, 1, 3'b000, 32'h100, 32'h0, 0, 32'h0);
    idle();
    do_op(1, 0, 3'b101, 32'h2, 32'h0, 99, 32'hFFFFFFFF);
    check_eq("timeout_keep", memData, 32'hAA000000);
    idle();

    // Asynchronous reset in the middle of a transaction
    valid_in  = 1'b1;
    is_load   = 1'b1;
    is_store  = 1'b0;
    funct3    = 3'b010;
    addr      = 32'h40;
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    valid_in = 1'b1;
    is_load  = 1'b1;
    is_store = 1'b0;
    funct3   = 3'b010;
    addr     = 32'h40;
    #1 check_eq("pre_rst_req", 32'(mem_req), 1);
    #1 reset = 1'b0;
    valid_in = 1'b0;
    #1;
    mdata = 32'h0;
    check_eq("async_req", 32'(mem_req), 0);
    check_eq("async_stall", 32'(stall), 0);
    check_eq("async_memdata", memData, 0);
    @(negedge clk);
    reset = 1'b1;
    idle();
    do_op(1, 0, 3'b010, 32'h10, 32'h0, 1, 32'h01020304);
    check_eq("lw_after_rst", memData, 32'h01020304);

    // Back-to-back: second op presented during the done pulse
    do_op(0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 32'h0);
    do_op(1, 0, 3'b001, 32'h2, 32'h0, 0, 32'h55667788);
    check_eq("b2b_lh", memData, 32'h55660000);
    idle();

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      int          kind = int'($urandom_range(0, 9));
      bit          il   = (kind < 4) || (kind == 8);
      bit          is_  = (kind >= 4 && kind < 8) || (kind == 8);
      logic [31:0] a    = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3));
      if (($urandom % 3) == 0) a = a & 32'hFFFF_FFFC;
      do_op(il, is_, 3'($urandom), a, $urandom, int'($urandom_range(0, 5)), $urandom);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) idle();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage sitting directly downstream of the execute stage.
- Takes the ALU result as the effective address, plus the store operand and the load/store funct3.
- Runs a request/ready transaction on the data-memory port and stalls the pipeline while the transaction is outstanding.
- Returns load data left-justified on memData: addressed byte in [31:24], addressed halfword in [31:16]. Execute sign- or zero-extends it from there.

Parameters:
XLEN, 32, datapath/address width
MAX_WAIT, 15, BUSY cycles without mem_ready before the transaction is aborted (1..255)

Ports:
clk  in  1  pipeline clock, all state on posedge
reset  in  1  asynchronous, active-low reset (0 = reset)
valid_in  in  1  execute presents a memory op this cycle
is_load  in  1  op is a load
is_store  in  1  op is a store
funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
addr  in  XLEN  effective address (resultALU)
store_data  in  XLEN  rs2 value for stores
mem_req  out  1  request valid to data memory
mem_we  out  1  1 = write
mem_addr  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables, bit i = bits [8i+7:8i] (little-endian lanes)
mem_ready  in  1  memory accepts/completes the request this cycle
mem_rdata  in  32  read word, valid when mem_ready=1
memData  out  32  left-justified load result to execute
stall  out  1  freeze upstream stages
done  out  1  one-cycle completion pulse
misaligned  out  1  one-cycle fault pulse: misaligned or illegal op
bus_err  out  1  one-cycle timeout pulse

Behaviour:
- Reset (reset=0, asynchronous), all outputs and state cleared immediately:
  - state=IDLE; mem_req, mem_we, mem_addr, mem_wdata, mem_be, memData, done, misaligned, bus_err = 0; wait counter = 0.
  - A transaction in flight is dropped with no done pulse.
- FSM states: IDLE, BUSY.
- A request (req) is valid_in & (is_load|is_store).
- An op is illegal if any of the following holds:
  - is_load & is_store both high;
  - load funct3 not in {000,001,010,100,101};
  - store funct3 not in {000,001,010};
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- IDLE behaviour:
  - req & legal: register mem_req=1, mem_we=is_store, mem_addr, mem_be, mem_wdata, load size/offset; counter=0; go to BUSY.
  - req & illegal: no memory request; misaligned=1 on the next cycle for one cycle; stay IDLE.
- stall is combinational: (state==IDLE & req & legal) | (state==BUSY).
- BUSY behaviour:
  - mem_req and all request fields held stable until mem_ready=1 is sampled.
  - On the posedge with mem_ready=1:
    - load: register memData.
    - store: memData unchanged.
    - done=1 for the next cycle; clear mem_req/mem_we/mem_be/mem_addr/mem_wdata; go to IDLE.
  - Otherwise counter increments. If counter==MAX_WAIT-1 and mem_ready=0: abort, clear the request fields, bus_err=1 for one cycle, memData unchanged, go to IDLE.
- Store lane rules:
  - SB: wdata={4{data[7:0]}}, be=0001<<addr[1:0].
  - SH: wdata={2{data[15:0]}}, be=0011 (off 0) or 1100 (off 2).
  - SW: wdata=data, be=1111.
- Load lane rules (b=addr[1:0]):
  - B/BU: memData={rdata[8b+7:8b],24'h0}.
  - H/HU: memData={rdata[16*b[1]+15:16*b[1]],16'h0}.
  - W: memData=rdata.
  - Sign/unsign is not applied here; execute applies it.
  - Loads use be=1111.
- Minimum latency: accept at cycle 0, BUSY with ready at cycle 1, done and memData valid at cycle 2. stall is high in cycles 0 and 1 only.
- Back-to-back: a new req may be accepted in the same cycle done is high.
- valid_in while BUSY is ignored, since upstream is stalled.
- mem_ready while IDLE is ignored.

Test Plan:
- LB addr=0x103, mem_ready=1 on the first BUSY cycle, rdata=0xAABBCCDD -> mem_addr=0x100, be=1111, memData=0xAA000000 two cycles after accept, done one cycle, stall exactly 2 cycles.
- SH addr=0x202, store_data=0x1234ABCD, ready after 3 BUSY cycles -> mem_we=1, mem_addr=0x200, wdata=0xABCDABCD, be=1100 held stable for 3 cycles, memData unchanged, done pulse.
- LW addr=0x101; then SH addr=0x7 -> no mem_req, misaligned pulse each, stall=0 throughout. Same result for is_load=is_store=1.
- MAX_WAIT=4, LHU addr=0x2, mem_ready held 0 -> mem_req high for 4 cycles then cleared, bus_err one cycle, done never, memData retains the prior value.
- reset driven low mid-BUSY between clock edges -> mem_req/stall drop immediately without waiting for clk. After release, LW addr=0x10 with rdata=0x01020304 -> memData=0x01020304.
- Back-to-back SW then LH addr=0x2 (rdata=0x55667788) with the second op presented during done -> accepted without an idle gap, memData=0x55660000.
